timer_device: RTL and testbench



---
 rtl/timer_pkg.sv | 36 +++
 rtl/timer_device.sv | 150 +++++++++++++++
 tb/tb_timer_device.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM state
// encoding, register word offsets, CTRL field positions and mode values.
package timer_pkg;

  // Controller states; the encoding is fixed so it can be matched in debug.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timer_state_e;

  // Word offsets on the 2-bit Addr bus (Addr = PrAddr[3:2]).
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL layout: only the low CTRL_W bits exist in hardware.
  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Operating modes after folding of the unused MODE encodings.
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Effective mode: encodings 2 and 3 behave exactly like one-shot.
  function automatic logic [1:0] ctrl_mode(input logic [CTRL_W-1:0] ctrl);
    logic [1:0] raw;
    raw = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
    return (raw == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_device.sv
// Countdown timer responding on the CPU bridge peripheral bus.
// CTRL enables the count and selects one-shot or auto-reload; PRESET holds
// the reload value; COUNT is the live, read-only down-counter. When the count
// expires a flag is raised, and IRQ reports flag qualified by the IM bit.
module timer_device
  import timer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Addr,
  input  logic              WE,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              IRQ
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  timer_state_e      state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              flag_q, flag_d;
  logic              irq_q, irq_d;

  logic ctrl_wr;
  logic preset_wr;
  logic fsm_set_flag;
  logic fsm_clr_flag;
  logic fsm_clr_en;

  // Bus write decode; COUNT and the reserved word have no write path.
  assign ctrl_wr   = WE && (Addr == ADDR_CTRL);
  assign preset_wr = WE && (Addr == ADDR_PRESET);

  // Next-state logic: FSM sequencing, counter, then register updates where a
  // CPU write has priority over the FSM and a flag set beats a flag clear.
  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    preset_d     = preset_q;
    count_d      = count_q;
    flag_d       = flag_q;
    fsm_set_flag = 1'b0;
    fsm_clr_flag = 1'b0;
    fsm_clr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_EN]) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // PRESET is sampled only here, so mid-count writes wait for reload.
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          // Disable freezes COUNT; a later enable reloads rather than resumes.
          state_d = IDLE;
        end else if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else begin
          // Covers both 1 and 0, so COUNT never wraps and PRESET 0 acts as 1.
          count_d      = '0;
          fsm_set_flag = 1'b1;
          state_d      = INT;
        end
      end
      INT: begin
        if (ctrl_mode(ctrl_q) == MODE_RELOAD) begin
          fsm_clr_flag = 1'b1;
          state_d      = LOAD;
        end else begin
          fsm_clr_en = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A CTRL write on the same edge as the one-shot EN clear wins.
    if (ctrl_wr) begin
      ctrl_d = Din[CTRL_W-1:0];
    end else if (fsm_clr_en) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end

    if (preset_wr) begin
      preset_d = Din;
    end

    // Any CTRL/PRESET write acknowledges the interrupt, unless expiry
    // happens on the very same edge.
    if (fsm_set_flag) begin
      flag_d = 1'b1;
    end else if (fsm_clr_flag || ctrl_wr || preset_wr) begin
      flag_d = 1'b0;
    end
  end

  // IRQ is held in its own flop, loaded with IM & flag as they will be after
  // this edge, so it always equals the registered IM & flag without glitches.
  assign irq_d = ctrl_d[CTRL_IM] & flag_d;

  // State and register update with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: every register is reset, including PRESET and COUNT, because
      // software may read any of them before ever writing.
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  // Zero-latency read mux; unused CTRL bits and the reserved word read 0.
  always_comb begin
    Dout = '0;
    case (Addr)
      ADDR_CTRL:   Dout = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: Dout = preset_q;
      ADDR_COUNT:  Dout = count_q;
      default:     Dout = '0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: a table of bus vectors, hand-written
// timing sequences, and a randomized run checked against an elapsed-time
// reference model.
module tb_timer_device;
  import timer_pkg::*;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              WE;
  logic [1:0]        Addr;
  logic [DATA_W-1:0] Din;
  logic [DATA_W-1:0] Dout;
  logic              IRQ;

  timer_device #(.DATA_W(DATA_W)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model. An enabled run is described by the number of cycles
  // since the enable was seen (m_step): step 1 loads PRESET, steps
  // 2..max(P,1)+1 count down, the next step is the interrupt cycle.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_p;
  logic        m_flag, m_active;
  longint      m_step;

  logic [31:0] s_dout;
  logic        s_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_ctrl = '0; m_preset = '0; m_count = '0; m_p = '0;
    m_flag = 1'b0; m_active = 1'b0; m_step = 0;
  endtask

  task automatic m_edge(input logic r, input logic we, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset, n_count, n_p;
    logic        n_flag, n_active, set_flag, clr_flag, clr_en;
    longint      n_step, fire_step;
    if (r) begin
      m_reset();
      return;
    end
    n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count; n_p = m_p;
    n_flag = m_flag; n_active = m_active; n_step = m_step;
    set_flag = 1'b0; clr_flag = 1'b0; clr_en = 1'b0;
    fire_step = ((m_p > 1) ? longint'(m_p) : 64'sd1) + 1;
    if (!m_active) begin
      if (m_ctrl[0]) begin n_active = 1'b1; n_step = 1; end
    end else if (m_step == 1) begin
      n_count = m_preset; n_p = m_preset; n_step = 2;
    end else if (m_step <= fire_step) begin
      if (!m_ctrl[0]) n_active = 1'b0;
      else if (m_step < fire_step) begin
        n_count = 32'(longint'(m_p) - (m_step - 1));
        n_step  = m_step + 1;
      end else begin
        n_count = '0; set_flag = 1'b1; n_step = m_step + 1;
      end
    end else begin
      if (m_ctrl[2:1] == 2'd1) begin clr_flag = 1'b1; n_step = 1; end
      else begin clr_en = 1'b1; n_active = 1'b0; end
    end
    if (we && a == 2'd0) n_ctrl = d[3:0];
    else if (clr_en) n_ctrl[0] = 1'b0;
    if (we && a == 2'd1) n_preset = d;
    if (set_flag) n_flag = 1'b1;
    else if (clr_flag || (we && (a == 2'd0 || a == 2'd1))) n_flag = 1'b0;
    m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_p = n_p;
    m_flag = n_flag; m_active = n_active; m_step = n_step;
  endtask

  // One bus cycle: apply inputs, sample and compare against the model,
  // then advance through the clock edge.
  task automatic drive(input logic r, input logic we, input logic [1:0] a,
                       input logic [31:0] d, output logic [31:0] dout_s, output logic irq_s);
    reset = r; WE = we; Addr = a; Din = d;
    #1;
    dout_s = Dout;
    irq_s  = IRQ;
    check("model_dout", dout_s, m_read(a));
    check("model_irq", {31'b0, irq_s}, {31'b0, m_ctrl[3] & m_flag});
    @(posedge clk);
    m_edge(r, we, a, d);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d, s_dout, s_irq);
  endtask

  task automatic idle(input logic [1:0] a);
    drive(1'b0, 1'b0, a, 32'h0, s_dout, s_irq);
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    reset = 1'b0; WE = 1'b0; Addr = a; Din = '0;
    #1;
    v = Dout;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic        r, we;
    logic [1:0]  a;
    logic [31:0] d;
    bit          found;

    // Reset for two cycles.
    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();

    // Test 1: register map after reset, read-only and reserved words.
    vecs[0]  = '{1'b0, 2'd0, 32'h0,          32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'd1, 32'h0,          32'h0,        1'b0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,          32'h0,        1'b0};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,          32'h0,        1'b0};
    vecs[4]  = '{1'b1, 2'd2, 32'h0000_0055,  32'h0,        1'b0};
    vecs[5]  = '{1'b0, 2'd2, 32'h0,          32'h0,        1'b0};
    vecs[6]  = '{1'b1, 2'd3, 32'hFFFF_FFFF,  32'h0,        1'b0};
    vecs[7]  = '{1'b0, 2'd3, 32'h0,          32'h0,        1'b0};
    vecs[8]  = '{1'b1, 2'd1, 32'hDEAD_BEEF,  32'h0,        1'b0};
    vecs[9]  = '{1'b0, 2'd1, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{1'b1, 2'd0, 32'hFFFF_FFF6,  32'h0,        1'b0};
    vecs[11] = '{1'b0, 2'd0, 32'h0,          32'h6,        1'b0};
    vecs[12] = '{1'b1, 2'd0, 32'h0,          32'h6,        1'b0};
    vecs[13] = '{1'b1, 2'd1, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 32'h0,          32'h0,        1'b0};
    vecs[15] = '{1'b0, 2'd1, 32'h0,          32'h0,        1'b0};
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, vecs[i].we, vecs[i].addr, vecs[i].din, s_dout, s_irq);
      check($sformatf("vec%0d_dout", i), s_dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_irq", i), {31'b0, s_irq}, {31'b0, vecs[i].exp_irq});
    end

    // Test 2: one-shot, PRESET=3, IRQ rises at t+6 and stays high.
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'h9);
    for (int k = 1; k <= 16; k++) begin
      idle(ADDR_CTRL);
      check($sformatf("t2_irq_k%0d", k), {31'b0, s_irq}, {31'b0, (k >= 6)});
      if (k == 5) check("t2_ctrl_before", s_dout, 32'h9);
      if (k == 7) check("t2_ctrl_after", s_dout, 32'h8);
    end
    peek(ADDR_COUNT, v);
    check("t2_count_zero", v, 32'h0);
    wr(ADDR_CTRL, 32'h8);
    check("t2_irq_before_ack", {31'b0, s_irq}, 32'h1);
    idle(ADDR_CTRL);
    check("t2_irq_after_ack", {31'b0, s_irq}, 32'h0);
    repeat (2) idle(ADDR_COUNT);

    // Test 3: auto-reload, PRESET=3, pulses at t+6, t+11, t+16.
    wr(ADDR_CTRL, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      idle(ADDR_CTRL);
      check($sformatf("t3_irq_k%0d", k), {31'b0, s_irq}, {31'b0, (k == 6 || k == 11 || k == 16)});
      check($sformatf("t3_ctrl_k%0d", k), s_dout, 32'hB);
    end
    wr(ADDR_CTRL, 32'h0);
    repeat (6) idle(ADDR_COUNT);

    // Test 4: IM=0 never raises IRQ; acknowledging write clears the flag.
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      idle(ADDR_CTRL);
      check($sformatf("t4_irq_k%0d", k), {31'b0, s_irq}, 32'h0);
      if (k == 2) check("t4_ctrl_running", s_dout, 32'h1);
      if (k == 8) check("t4_ctrl_expired", s_dout, 32'h0);
    end
    wr(ADDR_CTRL, 32'h8);
    for (int k = 1; k <= 4; k++) begin
      idle(ADDR_CTRL);
      check($sformatf("t4_irq_im_k%0d", k), {31'b0, s_irq}, 32'h0);
    end

    // Test 5: disable at COUNT=5 freezes at 4; re-enable reloads PRESET.
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      peek(ADDR_COUNT, v);
      if (v == 32'd5) found = 1'b1;
      else idle(ADDR_COUNT);
    end
    check("t5_reached_5", {31'b0, found}, 32'h1);
    wr(ADDR_CTRL, 32'h8);
    for (int k = 1; k <= 5; k++) begin
      idle(ADDR_COUNT);
      check($sformatf("t5_frozen_k%0d", k), s_dout, 32'd4);
    end
    wr(ADDR_CTRL, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      idle(ADDR_COUNT);
      check($sformatf("t5_reload_k%0d", k), s_dout, (k <= 2) ? 32'd4 : 32'(13 - k));
    end
    wr(ADDR_CTRL, 32'h0);
    repeat (4) idle(ADDR_COUNT);

    // Test 6: reset mid-count in auto-reload mode.
    wr(ADDR_CTRL, 32'hB);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      peek(ADDR_COUNT, v);
      if (v == 32'd7) found = 1'b1;
      else idle(ADDR_COUNT);
    end
    check("t6_reached_7", {31'b0, found}, 32'h1);
    drive(1'b1, 1'b0, ADDR_COUNT, 32'h0, s_dout, s_irq);
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), v);
      check($sformatf("t6_reg%0d_zero", i), v, 32'h0);
    end
    check("t6_irq_zero", {31'b0, IRQ}, 32'h0);
    for (int k = 1; k <= 30; k++) begin
      idle(ADDR_COUNT);
      check($sformatf("t6_quiet_k%0d", k), {31'b0, s_irq}, 32'h0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 5) == 0);
      a  = 2'($urandom_range(0, 3));
      if (a == ADDR_PRESET)
        d = ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12));
      else
        d = 32'($urandom);
      drive(r, we, a, d, s_dout, s_irq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
